// File: rtl/hdlc_pkg.sv
// Shared constants and state type for the HDLC receive path.
package hdlc_pkg;

  localparam logic [7:0]  FLAG_PATTERN = 8'h7E;
  localparam int unsigned STUFF_ONES   = 5;
  localparam int unsigned ABORT_ONES   = 7;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_channel_if.sv
// Line-side inputs and Rx-buffer-side outputs of the HDLC receive channel.
interface hdlc_rx_channel_if;

  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_StartFCS;
  logic       Rx_ValidFrame;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic       Rx_AbortSignal;
  logic       Rx_Overflow;
  logic [7:0] Rx_FrameSize;

  modport master (
    output Rx, RxEN,
    input  Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_StartFCS, Rx_ValidFrame,
    input  Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_Overflow, Rx_FrameSize
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_StartFCS, Rx_ValidFrame,
    output Rx_EoF, Rx_FrameError, Rx_AbortSignal, Rx_Overflow, Rx_FrameSize
  );

endinterface

// File: rtl/hdlc_rx_destuff.sv
// Raw line tracking: flag/abort detection and zero-bit deletion.
module hdlc_rx_destuff
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic rx,
  input  logic en,
  output logic bit_out,
  output logic bit_valid,
  output logic flag,
  output logic abort
);

  // Holds the previous 7 raw bits; with rx they form the 8-bit raw window.
  logic [6:0] raw;
  logic [2:0] ones;
  logic [7:0] window;

  always_comb begin
    window    = {rx, raw};
    bit_out   = rx;
    bit_valid = en && !(!rx && (ones == 3'(STUFF_ONES)));
    flag      = en && (window == FLAG_PATTERN);
    abort     = en && rx && (ones == 3'(ABORT_ONES - 1));
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      raw  <= '0;
      ones <= '0;
    end else if (en) begin
      raw <= window[7:1];
      if (!rx)
        ones <= '0;
      else if (ones != 3'(ABORT_ONES))
        ones <= ones + 3'd1;
    end
  end

endmodule

// File: rtl/hdlc_rx_channel.sv
// HDLC receive channel: flag hunt, destuffing, delay line, byte assembly and frame FSM.
module hdlc_rx_channel
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 128
) (
  input logic              Clk,
  input logic              Rst,
  hdlc_rx_channel_if.slave bus
);

  logic       d_bit, d_valid, flag, abort;
  rx_state_t  state, state_next;
  logic [7:0] dl_bit, dl_vld;
  logic [6:0] byte_sr;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] byte_cnt, byte_cnt_next;
  logic       have_data;
  logic       take, byte_done, over, clear;
  logic [7:0] byte_val;
  logic       new_byte, start_fcs, eof, ferr, abort_p, ovf;
  logic [7:0] rx_data, frame_size;
  logic       new_byte_q, flag_q, start_fcs_q, eof_q, ferr_q, abort_q, ovf_q;

  hdlc_rx_destuff u_destuff (
    .Clk       (Clk),
    .Rst       (Rst),
    .rx        (bus.Rx),
    .en        (bus.RxEN),
    .bit_out   (d_bit),
    .bit_valid (d_valid),
    .flag      (flag),
    .abort     (abort)
  );

  // The delay line only moves when a destuffed bit enters, so the exiting bit
  // is consumed in the same cycle; a coinciding flag then sees the updated counts.
  always_comb begin
    take          = d_valid && dl_vld[7] && (state == FRAME);
    byte_done     = take && (bit_cnt == 3'd7);
    byte_val      = {dl_bit[7], byte_sr};
    over          = byte_done && (byte_cnt == 8'(MAX_FRAME_BYTES));
    new_byte      = byte_done && !over;
    start_fcs     = new_byte && (byte_cnt == '0);
    bit_cnt_next  = take ? bit_cnt + 3'd1 : bit_cnt;
    byte_cnt_next = new_byte ? byte_cnt + 8'd1 : byte_cnt;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    eof        = 1'b0;
    ferr       = 1'b0;
    abort_p    = 1'b0;
    ovf        = 1'b0;
    case (state)
      HUNT: begin
        if (flag) begin
          state_next = FRAME;
          clear      = 1'b1;
        end
      end
      FRAME: begin
        if (over) begin
          ovf        = 1'b1;
          state_next = HUNT;
        end
        if (flag) begin
          state_next = FRAME;
          clear      = 1'b1;
          if (!over && ((byte_cnt_next != '0) || (bit_cnt_next != '0))) begin
            ferr = (bit_cnt_next != '0);
            eof  = (bit_cnt_next == '0);
          end
        end else if (abort) begin
          abort_p    = 1'b1;
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= HUNT;
    else      state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      dl_bit      <= '0;
      dl_vld      <= '0;
      byte_sr     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      have_data   <= 1'b0;
      rx_data     <= '0;
      frame_size  <= '0;
      new_byte_q  <= 1'b0;
      flag_q      <= 1'b0;
      start_fcs_q <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
      abort_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (d_valid) begin
        dl_bit <= {dl_bit[6:0], d_bit};
        dl_vld <= {dl_vld[6:0], 1'b1};
      end
      if (flag) dl_vld <= '0;
      if (take) byte_sr <= {dl_bit[7], byte_sr[6:1]};
      if (clear) begin
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        have_data <= 1'b0;
      end else begin
        bit_cnt  <= bit_cnt_next;
        byte_cnt <= byte_cnt_next;
        if (take) have_data <= 1'b1;
      end
      if (new_byte) begin
        rx_data    <= byte_val;
        frame_size <= byte_cnt + 8'd1;
      end
      new_byte_q  <= new_byte;
      flag_q      <= flag;
      start_fcs_q <= start_fcs;
      eof_q       <= eof;
      ferr_q      <= ferr;
      abort_q     <= abort_p;
      ovf_q       <= ovf;
    end
  end

  assign bus.Rx_Data        = rx_data;
  assign bus.Rx_NewByte     = new_byte_q;
  assign bus.Rx_FlagDetect  = flag_q;
  assign bus.Rx_StartFCS    = start_fcs_q;
  assign bus.Rx_ValidFrame  = (state == FRAME) && have_data;
  assign bus.Rx_EoF         = eof_q;
  assign bus.Rx_FrameError  = ferr_q;
  assign bus.Rx_AbortSignal = abort_q;
  assign bus.Rx_Overflow    = ovf_q;
  assign bus.Rx_FrameSize   = frame_size;

endmodule
